// File: rtl/pu_slave_spi_bank_if.sv
// pu_slave_spi_bank_if: NITTA-side and SPI-side signal bundle for pu_slave_spi_bank.
//   slave modport  : the processing unit (DUT) view.
//   master modport : the view of whoever drives NITTA control and the SPI master pins.
// Signals:
//   signal_cycle/signal_wr/data_in/attr_in/signal_oe : NITTA control and write data
//   data_out/attr_out/flag_start/flag_stop           : NITTA read data and status
//   mosi/sclk/cs (to slave), miso (from slave)       : SPI mode 0 pins, cs active low
interface pu_slave_spi_bank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATTR_WIDTH = 4
);
  logic                  signal_cycle;
  logic                  signal_wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ATTR_WIDTH-1:0] attr_in;
  logic                  signal_oe;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ATTR_WIDTH-1:0] attr_out;
  logic                  flag_start;
  logic                  flag_stop;
  logic                  mosi;
  logic                  miso;
  logic                  sclk;
  logic                  cs;

  modport slave (
    input  signal_cycle, signal_wr, data_in, attr_in, signal_oe, mosi, sclk, cs,
    output data_out, attr_out, flag_start, flag_stop, miso
  );

  modport master (
    output signal_cycle, signal_wr, data_in, attr_in, signal_oe, mosi, sclk, cs,
    input  data_out, attr_out, flag_start, flag_stop, miso
  );
endinterface

// File: rtl/pu_slave_spi_bank.sv
// pu_slave_spi_bank: SPI-slave processing unit with ping-pong buffering. Bank r_nb faces
// NITTA (writes via signal_wr, reads via signal_oe); bank !r_nb faces the SPI master
// (mode 0, MSB first). Banks swap on signal_cycle, deferred while a transaction runs.
// Ports:
//   clk  : system clock (must be >= 4x sclk)
//   rst  : asynchronous active-high reset
//   bus  : pu_slave_spi_bank_if.slave (NITTA control/data/status + SPI pins)
// attr_out: [0] invalid read, [1] spi overrun, [2] spi partial word, [3] write overflow.
module pu_slave_spi_bank #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ATTR_WIDTH  = 4,
  parameter int unsigned BUF_DEPTH   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  pu_slave_spi_bank_if.slave bus
);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);
  localparam logic [BW-1:0] LAST_BIT_C = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StActive, StDone} state_e;
  state_e r_state, w_state_d;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk, w_mosi, w_cs, w_sclk_rise, w_sclk_fall;

  logic [DATA_WIDTH-1:0] r_tx [2][BUF_DEPTH];
  logic [DATA_WIDTH-1:0] r_rx [2][BUF_DEPTH];
  logic [CW-1:0]         r_tx_count [2];
  logic [CW-1:0]         r_rx_count [2];

  logic                  r_nb, w_sb;
  logic [CW-1:0]         r_wr_ptr, r_oe_ptr, r_spi_ptr;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift, r_rx_shift;
  logic                  r_word_done, r_swap_pending;
  logic                  r_spi_overrun, r_spi_partial, r_wr_overflow;
  logic                  r_lat_overrun, r_lat_partial;
  logic                  w_swap_do, w_wr_ok, w_spi_full, w_oe_valid, w_tx_next_ok;
  logic [CW:0]           w_spi_ptr_inc;
  logic [DATA_WIDTH-1:0] w_tx_next;
  logic                  w_unused_attr;

  assign w_unused_attr = ^bus.attr_in;

  // Input synchronisers; cs idles high so its chain resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
      r_sclk_prev <= w_sclk;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;

  assign w_sb       = ~r_nb;
  assign w_swap_do  = (r_state == StIdle) && (bus.signal_cycle || r_swap_pending);
  assign w_wr_ok    = bus.signal_wr && (r_wr_ptr != DEPTH_C);
  assign w_spi_full = (r_spi_ptr == DEPTH_C);

  // Extra bit so the post-increment compare cannot wrap when BUF_DEPTH+1 is a power of 2.
  assign w_spi_ptr_inc = {1'b0, r_spi_ptr} + (CW+1)'(1);
  assign w_tx_next_ok  = w_spi_ptr_inc < {1'b0, r_tx_count[w_sb]};
  assign w_tx_next     = w_tx_next_ok ? r_tx[w_sb][w_spi_ptr_inc[AW-1:0]] : '0;

  // A swap wins over a simultaneous cs fall, so LOAD always sees the post-swap bank.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (!w_cs && !w_swap_do) w_state_d = StLoad;
      StLoad:   w_state_d = StActive;
      StActive: if (w_cs) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_nb           <= 1'b0;
      r_wr_ptr       <= '0;
      r_oe_ptr       <= '0;
      r_spi_ptr      <= '0;
      r_bit_cnt      <= '0;
      r_tx_shift     <= '0;
      r_rx_shift     <= '0;
      r_word_done    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_spi_overrun  <= 1'b0;
      r_spi_partial  <= 1'b0;
      r_wr_overflow  <= 1'b0;
      r_lat_overrun  <= 1'b0;
      r_lat_partial  <= 1'b0;
      r_tx_count[0]  <= '0;
      r_tx_count[1]  <= '0;
      r_rx_count[0]  <= '0;
      r_rx_count[1]  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_word_done <= 1'b0;

      if (r_state == StLoad) begin
        r_tx_shift <= (r_tx_count[w_sb] != '0) ? r_tx[w_sb][0] : '0;
        r_bit_cnt  <= '0;
        r_spi_ptr  <= '0;
      end

      if (r_state == StActive) begin
        if (w_sclk_rise) begin
          r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
          if (r_bit_cnt == LAST_BIT_C) begin
            r_bit_cnt   <= '0;
            r_word_done <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        // bit_cnt==0 on a fall means a fresh word was just loaded: keep its MSB on miso.
        if (w_sclk_fall && r_bit_cnt != '0) begin
          r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
        if (w_cs && r_bit_cnt != '0) r_spi_partial <= 1'b1;
      end

      if (r_word_done) begin
        if (w_spi_full) r_spi_overrun <= 1'b1;
        else            r_spi_ptr     <= w_spi_ptr_inc[CW-1:0];
        r_tx_shift <= w_tx_next;
      end

      if (r_state == StDone) r_rx_count[w_sb] <= r_spi_ptr;

      if (bus.signal_cycle && r_state != StIdle) r_swap_pending <= 1'b1;

      if (w_wr_ok)                    r_wr_ptr      <= r_wr_ptr + CW'(1);
      else if (bus.signal_wr)         r_wr_overflow <= 1'b1;
      if (bus.signal_oe && r_oe_ptr != DEPTH_C) r_oe_ptr <= r_oe_ptr + CW'(1);

      // Swap last so it overrides the write/read pointer updates of the same cycle.
      if (w_swap_do) begin
        r_nb             <= ~r_nb;
        r_wr_ptr         <= '0;
        r_oe_ptr         <= '0;
        r_tx_count[r_nb] <= r_wr_ptr + CW'(w_wr_ok);
        r_tx_count[w_sb] <= '0;
        r_lat_overrun    <= r_spi_overrun;
        r_lat_partial    <= r_spi_partial;
        r_spi_overrun    <= 1'b0;
        r_spi_partial    <= 1'b0;
        r_wr_overflow    <= 1'b0;
        r_swap_pending   <= 1'b0;
      end
    end
  end

  // Buffer storage carries no reset; counts gate every read.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_tx[r_nb][r_wr_ptr[AW-1:0]] <= bus.data_in;
    if (r_word_done && !w_spi_full) r_rx[w_sb][r_spi_ptr[AW-1:0]] <= r_rx_shift;
  end

  assign w_oe_valid   = r_oe_ptr < r_rx_count[r_nb];
  assign bus.data_out = (bus.signal_oe && w_oe_valid) ? r_rx[r_nb][r_oe_ptr[AW-1:0]] : '0;

  always_comb begin
    bus.attr_out    = '0;
    bus.attr_out[0] = bus.signal_oe && !w_oe_valid;
    bus.attr_out[1] = r_lat_overrun;
    bus.attr_out[2] = r_lat_partial;
    bus.attr_out[3] = r_wr_overflow;
  end

  assign bus.miso       = (r_state == StActive) ? r_tx_shift[DATA_WIDTH-1] : 1'b0;
  assign bus.flag_start = (r_state == StActive);
  assign bus.flag_stop  = (r_state == StIdle) && !r_swap_pending;
endmodule

// File: tb/tb_pu_slave_spi_bank.sv
// tb_pu_slave_spi_bank: directed bench for pu_slave_spi_bank. Drives NITTA writes/reads and
// acts as a mode-0 SPI master; expected miso words and expected read results are queued
// as stimulus is issued and popped when the DUT produces them.
module tb_pu_slave_spi_bank;
  localparam int unsigned DW   = 32;
  localparam int unsigned AWD  = 4;
  localparam int          HALF = 8;  // clk cycles per sclk half period

  typedef struct {
    logic [31:0] data;
    logic [3:0]  attr;
  } rd_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] exp_miso[$];
  rd_t         exp_rd[$];

  pu_slave_spi_bank_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AWD)) bus ();

  pu_slave_spi_bank #(
    .DATA_WIDTH (DW),
    .ATTR_WIDTH (AWD),
    .BUF_DEPTH  (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nitta_write(input logic [31:0] d);
    @(negedge clk);
    bus.data_in   = d;
    bus.signal_wr = 1'b1;
    @(negedge clk);
    bus.signal_wr = 1'b0;
  endtask

  task automatic pulse_cycle();
    @(negedge clk);
    bus.signal_cycle = 1'b1;
    @(negedge clk);
    bus.signal_cycle = 1'b0;
  endtask

  task automatic nitta_read(input string tag);
    rd_t e;
    @(negedge clk);
    bus.signal_oe = 1'b1;
    #1;
    if (exp_rd.size() == 0) begin
      e.data = 'x;
      e.attr = 'x;
    end else begin
      e = exp_rd.pop_front();
    end
    check({tag, "_data"}, bus.data_out, e.data);
    check({tag, "_attr"}, bus.attr_out, e.attr);
    @(negedge clk);
    bus.signal_oe = 1'b0;
  endtask

  task automatic spi_bits(input int nbits, input logic [31:0] mo, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[31-i];
      repeat (HALF) @(negedge clk);
      mi = {mi[30:0], bus.miso};
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_word(input string tag, input logic [31:0] mo);
    logic [31:0] mi;
    logic [31:0] e;
    spi_bits(32, mo, mi);
    if (exp_miso.size() == 0) e = 'x;
    else                      e = exp_miso.pop_front();
    check(tag, mi, e);
  endtask

  task automatic cs_begin(input string tag);
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    check(tag, bus.flag_start, 1'b1);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_stop(input string tag);
    int n = 0;
    while (bus.flag_stop !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.flag_stop, 1'b1);
  endtask

  initial begin
    logic [31:0] mi;
    bus.signal_cycle = 1'b0;
    bus.signal_wr    = 1'b0;
    bus.data_in      = '0;
    bus.attr_in      = '0;
    bus.signal_oe    = 1'b0;
    bus.mosi         = 1'b0;
    bus.sclk         = 1'b0;
    bus.cs           = 1'b1;
    rst              = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flag_stop", bus.flag_stop, 1'b1);
    check("rst_flag_start", bus.flag_start, 1'b0);
    check("rst_miso", bus.miso, 1'b0);
    check("rst_attr", bus.attr_out, 4'h0);
    check("rst_data", bus.data_out, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two words out, two words in.
    nitta_write(32'hA1B2C3D4);
    nitta_write(32'h11223344);
    pulse_cycle();
    exp_miso.push_back(32'hA1B2C3D4);
    exp_miso.push_back(32'h11223344);
    cs_begin("t1_flag_start");
    check("t1_flag_stop_busy", bus.flag_stop, 1'b0);
    spi_word("t1_miso0", 32'hDEADBEEF);
    spi_word("t1_miso1", 32'h01234567);
    cs_end();
    pulse_cycle();
    exp_rd.push_back('{32'hDEADBEEF, 4'h0});
    exp_rd.push_back('{32'h01234567, 4'h0});
    exp_rd.push_back('{32'h0, 4'h1});
    nitta_read("t1_rd0");
    nitta_read("t1_rd1");
    nitta_read("t1_rd2");

    // Write overflow and SPI overrun.
    nitta_write(32'h10000000);
    nitta_write(32'h20000001);
    nitta_write(32'h30000002);
    nitta_write(32'h40000003);
    nitta_write(32'h50000004);
    @(negedge clk);
    check("t3_wr_overflow", bus.attr_out, 4'h8);
    pulse_cycle();
    check("t3_attr_after_swap", bus.attr_out, 4'h0);
    exp_miso.push_back(32'h10000000);
    exp_miso.push_back(32'h20000001);
    exp_miso.push_back(32'h30000002);
    exp_miso.push_back(32'h40000003);
    exp_miso.push_back(32'h0);
    cs_begin("t3_flag_start");
    spi_word("t3_miso0", 32'hC0000000);
    spi_word("t3_miso1", 32'hC1111111);
    spi_word("t3_miso2", 32'hC2222222);
    spi_word("t3_miso3", 32'hC3333333);
    spi_word("t3_miso4", 32'hC4444444);
    cs_end();
    pulse_cycle();
    check("t3_overrun_attr", bus.attr_out, 4'h2);
    exp_rd.push_back('{32'hC0000000, 4'h2});
    exp_rd.push_back('{32'hC1111111, 4'h2});
    exp_rd.push_back('{32'hC2222222, 4'h2});
    exp_rd.push_back('{32'hC3333333, 4'h2});
    exp_rd.push_back('{32'h0, 4'h3});
    for (int i = 0; i < 5; i++) nitta_read($sformatf("t3_rd%0d", i));

    // Full word then a 12-bit partial.
    exp_miso.push_back(32'h0);
    cs_begin("t4_flag_start");
    spi_word("t4_miso0", 32'h5A5AA5A5);
    spi_bits(12, 32'hFFFFFFFF, mi);
    cs_end();
    pulse_cycle();
    exp_rd.push_back('{32'h5A5AA5A5, 4'h4});
    exp_rd.push_back('{32'h0, 4'h5});
    nitta_read("t4_rd0");
    nitta_read("t4_rd1");

    // Swap requested mid-transaction, requested twice.
    cs_begin("t5_flag_start");
    pulse_cycle();
    check("t5_flag_stop_pending", bus.flag_stop, 1'b0);
    pulse_cycle();
    nitta_write(32'h77777777);
    exp_miso.push_back(32'h0);
    spi_word("t5_miso0", 32'h13572468);
    repeat (HALF) @(negedge clk);
    bus.cs = 1'b1;
    @(negedge clk);
    check("t5_flag_stop_deferred", bus.flag_stop, 1'b0);
    wait_stop("t5_wait_stop");
    exp_rd.push_back('{32'h13572468, 4'h0});
    exp_rd.push_back('{32'h0, 4'h1});
    nitta_read("t5_rd0");
    nitta_read("t5_rd1");

    // Reset mid-word, then a clean transaction with write coincident with swap.
    cs_begin("t6_flag_start");
    spi_bits(10, 32'hFFFFFFFF, mi);
    check("t6_partial_miso", mi, 32'h1DD);
    @(negedge clk);
    rst    = 1'b1;
    bus.cs = 1'b1;
    #1;
    check("t6_rst_miso", bus.miso, 1'b0);
    check("t6_rst_flag_stop", bus.flag_stop, 1'b1);
    check("t6_rst_flag_start", bus.flag_start, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_rd.push_back('{32'h0, 4'h1});
    nitta_read("t6_rd_empty");
    @(negedge clk);
    bus.data_in      = 32'hC0FFEE01;
    bus.signal_wr    = 1'b1;
    bus.signal_cycle = 1'b1;
    @(negedge clk);
    bus.signal_wr    = 1'b0;
    bus.signal_cycle = 1'b0;
    exp_miso.push_back(32'hC0FFEE01);
    exp_miso.push_back(32'h0);
    cs_begin("t6_flag_start2");
    spi_word("t6_miso0", 32'h0F0F0F0F);
    spi_word("t6_miso1", 32'hF0F0F0F0);
    cs_end();
    pulse_cycle();
    exp_rd.push_back('{32'h0F0F0F0F, 4'h0});
    exp_rd.push_back('{32'hF0F0F0F0, 4'h0});
    exp_rd.push_back('{32'h0, 4'h1});
    nitta_read("t6_rd0");
    nitta_read("t6_rd1");
    nitta_read("t6_rd2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pu_slave_spi_bank.md
Name: pu_slave_spi_bank

Overview:
Parametrised SPI-slave processing unit with ping-pong (double-banked) buffering between the NITTA bus and an external SPI master (mode 0, MSB first). One bank faces NITTA (written via signal_wr, read via signal_oe) while the other faces SPI. Banks swap on signal_cycle, deferred if an SPI transaction is in progress. Adds configurable word width, bank depth, per-bank word counts and overrun/underrun status in attr_out.

Parameters:
DATA_WIDTH, 32, NITTA word width and SPI word length in bits (must be a multiple of 8)
ATTR_WIDTH, 4, attribute width (>= 4)
BUF_DEPTH, 4, words per direction per bank (>= 1)
SYNC_STAGES, 2, synchroniser depth on sclk/mosi/cs (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
signal_cycle  in  1  computation-cycle boundary; requests bank swap
signal_wr  in  1  write data_in into NITTA-side TX bank
data_in  in  DATA_WIDTH  word to send to master
attr_in  in  ATTR_WIDTH  ignored
signal_oe  in  1  read next word from NITTA-side RX bank
data_out  out  DATA_WIDTH  word received from master
attr_out  out  ATTR_WIDTH  status, see Behaviour
flag_start  out  1  high while SPI transaction active
flag_stop  out  1  high when SPI idle and no swap pending
mosi  in  1  SPI data in
miso  out  1  SPI data out
sclk  in  1  SPI clock (async to clk)
cs  in  1  SPI chip select, active low

Behaviour:
- Reset (async): bank select nb=0; all pointers/counts 0; SPI FSM IDLE; swap_pending=0; miso=0; data_out=0; attr_out=0; flag_start=0; flag_stop=1.
- sclk, mosi, cs pass through SYNC_STAGES flops; edges detected on synchronised sclk. Requires clk >= 4x sclk.
- SPI FSM: IDLE -(cs falls)-> LOAD (1 cycle: shift_reg <= tx[!nb][0], or 0 if tx_count[!nb]==0; bit_cnt=0; spi_ptr=0) -> ACTIVE -(cs rises)-> DONE (1 cycle) -> IDLE.
- ACTIVE: rising sclk samples mosi into rx shift; falling sclk shifts tx; miso = tx shift MSB, 0 outside ACTIVE.
- Word completes after DATA_WIDTH rising edges. One cycle later rx[!nb][spi_ptr] <= rx word if spi_ptr < BUF_DEPTH, else drop and set spi_overrun. spi_ptr++. Next tx word = tx[!nb][spi_ptr] if spi_ptr < tx_count[!nb], else 0.
- cs rise with bit_cnt != 0: partial word discarded, set spi_partial.
- DONE: rx_count[!nb] <= min(spi_ptr, BUF_DEPTH).
- NITTA write: signal_wr stores data_in to tx[nb][wr_ptr] and increments wr_ptr when wr_ptr < BUF_DEPTH; at BUF_DEPTH the write is dropped and wr_overflow is set (sticky until swap).
- NITTA read: data_out is combinational from rx[nb][oe_ptr] while signal_oe is high; oe_ptr increments on the clock edge. If oe_ptr >= rx_count[nb], data_out=0 and attr_out[0]=1. data_out=0 when signal_oe is low.
- attr_out bits: [0] invalid read (combinational, with signal_oe); [1] spi_overrun; [2] spi_partial; [3] wr_overflow; upper bits 0. Bits [2:1] are latched at swap from the completed SPI bank's flags.
- Swap on signal_cycle:
  - In IDLE: the next cycle nb toggles; wr_ptr=0, oe_ptr=0; tx_count[old nb] <= wr_ptr; the new NITTA TX bank is cleared (count 0); SPI-side flags are cleared.
  - In LOAD/ACTIVE/DONE: swap_pending=1 and the swap executes in the cycle after DONE.
  - signal_cycle while swap_pending is already set: ignored.
  - signal_cycle coincident with signal_wr: the write goes to the old bank, then the swap occurs.
- flag_start = (state == ACTIVE). flag_stop = (state == IDLE) && !swap_pending.
- Mid-operation reset: all state clears immediately; miso=0; the in-flight word is lost.

Test Plan:
- After reset, write 0xA1B2C3D4 and 0x11223344, pulse signal_cycle, master clocks 64 bits -> miso returns A1B2C3D4 then 11223344 MSB first; flag_start high during the transaction.
- Master sends 0xDEADBEEF, cs rises, pulse signal_cycle, signal_oe twice -> data_out DEADBEEF with attr_out=0, then 0 with attr_out[0]=1.
- BUF_DEPTH=4: master sends 5 words -> after swap, 4 words readable and attr_out[1]=1; 5 signal_wr writes -> attr_out[3]=1 and the 5th word is never transmitted.
- cs rises after 12 bits -> partial word dropped; attr_out[2]=1 after swap; rx_count unchanged.
- signal_cycle asserted mid-transaction -> flag_stop=0, nb unchanged until the cycle after DONE, then swaps; a second signal_cycle while pending causes no extra swap.
- rst asserted mid-word -> miso=0, flag_stop=1, all counts 0; a following full transaction works normally.
